// File: rtl/lifo_stack_ctrl_if.sv
// Request/status and RAM control bundle for lifo_stack_ctrl; the shared RAM data bus stays a plain inout.
// The PEEK request exists only when LIFO_PEEK_EN is defined.
interface lifo_stack_ctrl_if #(
    parameter int DW = 8,
    parameter int AW = 5
);
    logic          PUSH;
    logic          POP;
`ifdef LIFO_PEEK_EN
    logic          PEEK;
`endif
    logic [DW-1:0] DIN;
    logic [DW-1:0] DOUT;
    logic          DOUT_VALID;
    logic          BUSY;
    logic          FULL;
    logic          EMPTY;
    logic [AW:0]   COUNT;
    logic          OVF;
    logic          UNF;
    logic [AW-1:0] RAM_ADDR;
    logic          RAM_WEN;
    logic          RAM_RWS;
    logic          RAM_CS;

    modport master (
`ifdef LIFO_PEEK_EN
        output PEEK,
`endif
        output PUSH, POP, DIN,
        input  DOUT, DOUT_VALID, BUSY, FULL, EMPTY, COUNT, OVF, UNF,
        input  RAM_ADDR, RAM_WEN, RAM_RWS, RAM_CS
    );

    modport slave (
`ifdef LIFO_PEEK_EN
        input  PEEK,
`endif
        input  PUSH, POP, DIN,
        output DOUT, DOUT_VALID, BUSY, FULL, EMPTY, COUNT, OVF, UNF,
        output RAM_ADDR, RAM_WEN, RAM_RWS, RAM_CS
    );
endinterface

// File: rtl/lifo_stack_ctrl.sv
// Stack-pointer sequencer for a shared-bus 32x8 stack RAM: PUSH/POP/(PEEK) to RAM strobe sequences.
// Optional non-destructive read of the top word is enabled by defining LIFO_PEEK_EN.
module lifo_stack_ctrl #(
    parameter int DW    = 8,
    parameter int AW    = 5,
    parameter int DEPTH = 32
) (
    input  logic             CLK,
    input  logic             RST_N,
    lifo_stack_ctrl_if.slave bus,
    inout  wire  [DW-1:0]    RAM_IO
);
    localparam logic [AW:0] L_DEPTH = (AW+1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_W_SETUP,
        S_W_STROBE,
        S_W_HOLD,
        S_R_SETUP,
        S_R_CAPT
    } state_t;

    state_t        r_state;
    logic [AW:0]   r_count;
    logic          r_full;
    logic          r_empty;
    logic [DW-1:0] r_dout;
    logic          r_dout_valid;
    logic          r_busy;
    logic          r_ovf;
    logic          r_unf;
    logic [AW-1:0] r_addr;
    logic          r_wen;
    logic          r_rws;
    logic          r_cs;
    logic [DW-1:0] r_wdata;
    logic          r_drv;

    logic [AW:0]   w_cnt_inc;
    logic [AW:0]   w_cnt_dec;
    logic          w_consume;

    assign w_cnt_inc = r_count + 1'b1;
    assign w_cnt_dec = r_count - 1'b1;

`ifdef LIFO_PEEK_EN
    logic r_peek;
    assign w_consume = !r_peek;
`else
    assign w_consume = 1'b1;
`endif

    // Bus is only ever driven from flops, so the drive window lines up exactly with the write states.
    assign RAM_IO = r_drv ? r_wdata : {DW{1'bz}};

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state      <= S_IDLE;
            r_count      <= '0;
            r_full       <= 1'b0;
            r_empty      <= 1'b1;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_ovf        <= 1'b0;
            r_unf        <= 1'b0;
            r_addr       <= '0;
            r_wen        <= 1'b0;
            r_rws        <= 1'b1;
            r_cs         <= 1'b0;
            r_wdata      <= '0;
            r_drv        <= 1'b0;
`ifdef LIFO_PEEK_EN
            r_peek       <= 1'b0;
`endif
        end else begin
            r_dout_valid <= 1'b0;
            r_ovf        <= 1'b0;
            r_unf        <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.POP && !r_empty) begin
                        r_state <= S_R_SETUP;
                        r_addr  <= w_cnt_dec[AW-1:0];
                        r_rws   <= 1'b0;
                        r_cs    <= 1'b1;
                        r_busy  <= 1'b1;
`ifdef LIFO_PEEK_EN
                        r_peek  <= 1'b0;
`endif
                    end else if (bus.PUSH && !r_full) begin
                        r_state <= S_W_SETUP;
                        r_addr  <= r_count[AW-1:0];
                        r_wdata <= bus.DIN;
                        r_drv   <= 1'b1;
                        r_rws   <= 1'b1;
                        r_cs    <= 1'b1;
                        r_busy  <= 1'b1;
                    end else if (bus.PUSH) begin
                        r_ovf <= 1'b1;
                    end else if (bus.POP) begin
                        r_unf <= 1'b1;
`ifdef LIFO_PEEK_EN
                    end else if (bus.PEEK && !r_empty) begin
                        r_state <= S_R_SETUP;
                        r_addr  <= w_cnt_dec[AW-1:0];
                        r_rws   <= 1'b0;
                        r_cs    <= 1'b1;
                        r_busy  <= 1'b1;
                        r_peek  <= 1'b1;
                    end else if (bus.PEEK) begin
                        r_unf <= 1'b1;
`endif
                    end
                end
                S_W_SETUP: begin
                    r_state <= S_W_STROBE;
                    r_wen   <= 1'b1;
                end
                S_W_STROBE: begin
                    r_state <= S_W_HOLD;
                    r_wen   <= 1'b0;
                end
                S_W_HOLD: begin
                    r_state <= S_IDLE;
                    r_count <= w_cnt_inc;
                    r_full  <= (w_cnt_inc == L_DEPTH);
                    r_empty <= 1'b0;
                    r_cs    <= 1'b0;
                    r_drv   <= 1'b0;
                    r_busy  <= 1'b0;
                end
                S_R_SETUP: begin
                    r_state <= S_R_CAPT;
                end
                S_R_CAPT: begin
                    r_state      <= S_IDLE;
                    r_dout       <= RAM_IO;
                    r_dout_valid <= 1'b1;
                    r_cs         <= 1'b0;
                    r_rws        <= 1'b1;
                    r_busy       <= 1'b0;
                    if (w_consume) begin
                        r_count <= w_cnt_dec;
                        r_empty <= (w_cnt_dec == '0);
                        r_full  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cs    <= 1'b0;
                    r_wen   <= 1'b0;
                    r_rws   <= 1'b1;
                    r_drv   <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.DOUT       = r_dout;
    assign bus.DOUT_VALID = r_dout_valid;
    assign bus.BUSY       = r_busy;
    assign bus.FULL       = r_full;
    assign bus.EMPTY      = r_empty;
    assign bus.COUNT      = r_count;
    assign bus.OVF        = r_ovf;
    assign bus.UNF        = r_unf;
    assign bus.RAM_ADDR   = r_addr;
    assign bus.RAM_WEN    = r_wen;
    assign bus.RAM_RWS    = r_rws;
    assign bus.RAM_CS     = r_cs;

    a_no_contention: assert property (@(posedge CLK) disable iff (!RST_N) !(r_drv && !r_rws));
    a_count_range:   assert property (@(posedge CLK) disable iff (!RST_N) r_count <= L_DEPTH);
    a_wen_in_cs:     assert property (@(posedge CLK) disable iff (!RST_N) !(r_wen && !r_cs));
endmodule

// File: tb/tb_lifo_stack_ctrl.sv
// Bench for lifo_stack_ctrl: directed vector table, hand sequences and random ops vs a queue model.
module tb_lifo_stack_ctrl;
    localparam int DW    = 8;
    localparam int AW    = 5;
    localparam int DEPTH = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lifo_stack_ctrl_if #(.DW(DW), .AW(AW)) bus ();
    wire [DW-1:0] ram_io;

    lifo_stack_ctrl #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) dut (
        .CLK    (clk),
        .RST_N  (rst_n),
        .bus    (bus),
        .RAM_IO (ram_io)
    );

    // RAM model drives on read; a random probe drives whenever the RAM is deselected,
    // so any stray controller drive corrupts the probe value.
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] probe_val = 8'h00;
    assign ram_io = (bus.RAM_CS && !bus.RAM_RWS) ? mem[bus.RAM_ADDR] : {DW{1'bz}};
    assign ram_io = (!bus.RAM_CS) ? probe_val : {DW{1'bz}};

    always @(posedge clk) begin
        if (bus.RAM_CS && bus.RAM_WEN && bus.RAM_RWS) mem[bus.RAM_ADDR] <= ram_io;
        probe_val <= DW'($urandom);
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    bit   mon_en  = 1'b0;
    logic prev_wr = 1'b0;
    always @(negedge clk) begin
        if (mon_en) begin
            if (!bus.RAM_CS) chk("bus_released", 32'(ram_io), 32'(probe_val));
            else if (!bus.RAM_RWS) begin
                chk("bus_read_clean", 32'(ram_io), 32'(mem[bus.RAM_ADDR]));
                chk("turnaround_gap", 32'(prev_wr), 32'd0);
            end
            prev_wr = bus.RAM_CS && bus.RAM_RWS;
        end
    end

    // Reference model: a plain queue, top of stack at the back.
    logic [DW-1:0] q[$];
    logic [DW-1:0] m_dout = '0;

    task automatic set_req(input logic pu, input logic po, input logic pk, input logic [DW-1:0] d);
        bus.PUSH = pu;
        bus.POP  = po;
`ifdef LIFO_PEEK_EN
        bus.PEEK = pk;
`else
        if (pk) $display("peek requested in a build without peek");
`endif
        bus.DIN  = d;
    endtask

    task automatic do_op(input logic pu, input logic po, input logic pk, input logic [DW-1:0] d,
                         output bit o_ovf, output bit o_unf, output int o_busy);
        int            exp_busy, exp_addr, busy;
        bit            exp_dv, exp_ovf, exp_unf, exp_rws;
        logic [2:0]    exp_wen, wen_mask;
        logic [AW-1:0] addr0;
        logic          rws0;
        exp_busy = 0; exp_addr = 0; exp_dv = 0; exp_ovf = 0; exp_unf = 0; exp_rws = 1; exp_wen = 3'b000;
        if (po && q.size() > 0) begin
            exp_busy = 2; exp_dv = 1; exp_addr = q.size() - 1; exp_rws = 0; m_dout = q.pop_back();
        end else if (pu && q.size() < DEPTH) begin
            exp_busy = 3; exp_addr = q.size(); exp_wen = 3'b010; q.push_back(d);
        end else if (pu) exp_ovf = 1;
        else if (po) exp_unf = 1;
        else if (pk && q.size() > 0) begin
            exp_busy = 2; exp_dv = 1; exp_addr = q.size() - 1; exp_rws = 0; m_dout = q[$];
        end else if (pk) exp_unf = 1;

        @(negedge clk); set_req(pu, po, pk, d);
        @(negedge clk); set_req(1'b0, 1'b0, 1'b0, DW'($urandom));
        busy = 0; wen_mask = '0; addr0 = '0; rws0 = 1'b1;
        while (bus.BUSY && busy < 8) begin
            if (busy == 0) begin addr0 = bus.RAM_ADDR; rws0 = bus.RAM_RWS; end
            if (busy < 3) wen_mask[busy] = bus.RAM_WEN;
            chk("cs_during_busy", 32'(bus.RAM_CS), 32'd1);
            busy++;
            @(negedge clk);
        end
        chk("busy_len", 32'(busy), 32'(exp_busy));
        if (exp_busy > 0) begin
            chk("ram_addr", 32'(addr0), 32'(exp_addr));
            chk("ram_rws", 32'(rws0), 32'(exp_rws));
            chk("wen_shape", 32'(wen_mask), 32'(exp_wen));
        end
        chk("dout_valid", 32'(bus.DOUT_VALID), 32'(exp_dv));
        chk("ovf", 32'(bus.OVF), 32'(exp_ovf));
        chk("unf", 32'(bus.UNF), 32'(exp_unf));
        chk("dout", 32'(bus.DOUT), 32'(m_dout));
        chk("count", 32'(bus.COUNT), 32'(q.size()));
        chk("empty", 32'(bus.EMPTY), 32'(q.size() == 0));
        chk("full", 32'(bus.FULL), 32'(q.size() == DEPTH));
        o_ovf = bus.OVF; o_unf = bus.UNF; o_busy = busy;
        @(negedge clk);
        chk("pulse_width", 32'({bus.DOUT_VALID, bus.OVF, bus.UNF}), 32'd0);
    endtask

    typedef struct {
        logic          pu, po;
        logic [DW-1:0] din;
        int            busy;
        logic [DW-1:0] dout;
        int            cnt;
        bit            ovf, unf;
    } vec_t;

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_count"}, 32'(bus.COUNT), 32'd0);
        chk({tag, "_empty"}, 32'(bus.EMPTY), 32'd1);
        chk({tag, "_full"},  32'(bus.FULL), 32'd0);
        chk({tag, "_dout"},  32'(bus.DOUT), 32'd0);
        chk({tag, "_flags"}, 32'({bus.DOUT_VALID, bus.OVF, bus.UNF, bus.BUSY}), 32'd0);
        chk({tag, "_ram"},   32'({bus.RAM_CS, bus.RAM_WEN, bus.RAM_RWS}), 32'b001);
        chk({tag, "_addr"},  32'(bus.RAM_ADDR), 32'd0);
        chk({tag, "_io_z"},  32'(ram_io), 32'(probe_val));
    endtask

    initial begin
        vec_t vt[14];
        bit   ov, un;
        int   bl, n;

        vt[0]  = '{1, 0, 8'hA5, 3, 8'h00, 1, 0, 0};
        vt[1]  = '{0, 1, 8'h00, 2, 8'hA5, 0, 0, 0};
        vt[2]  = '{0, 1, 8'h00, 0, 8'hA5, 0, 0, 1};
        vt[3]  = '{1, 0, 8'h11, 3, 8'hA5, 1, 0, 0};
        vt[4]  = '{1, 0, 8'h22, 3, 8'hA5, 2, 0, 0};
        vt[5]  = '{1, 1, 8'h99, 2, 8'h22, 1, 0, 0};
        vt[6]  = '{1, 0, 8'h22, 3, 8'h22, 2, 0, 0};
        vt[7]  = '{1, 0, 8'h33, 3, 8'h22, 3, 0, 0};
        vt[8]  = '{0, 1, 8'h00, 2, 8'h33, 2, 0, 0};
        vt[9]  = '{0, 1, 8'h00, 2, 8'h22, 1, 0, 0};
        vt[10] = '{0, 1, 8'h00, 2, 8'h11, 0, 0, 0};
        vt[11] = '{1, 1, 8'h44, 3, 8'h11, 1, 0, 0};
        vt[12] = '{0, 1, 8'h00, 2, 8'h44, 0, 0, 0};
        vt[13] = '{0, 0, 8'h00, 0, 8'h44, 0, 0, 0};

        set_req(1'b0, 1'b0, 1'b0, '0);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_vals("rst");
        rst_n = 1'b1;
        mon_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("idle_empty", 32'(bus.EMPTY), 32'd1);
            chk("idle_count", 32'(bus.COUNT), 32'd0);
            chk("idle_cs", 32'(bus.RAM_CS), 32'd0);
        end

        for (int i = 0; i < 14; i++) begin
            do_op(vt[i].pu, vt[i].po, 1'b0, vt[i].din, ov, un, bl);
            chk("tbl_busy", 32'(bl), 32'(vt[i].busy));
            chk("tbl_dout", 32'(bus.DOUT), 32'(vt[i].dout));
            chk("tbl_count", 32'(bus.COUNT), 32'(vt[i].cnt));
            chk("tbl_ovf", 32'(ov), 32'(vt[i].ovf));
            chk("tbl_unf", 32'(un), 32'(vt[i].unf));
        end

        // Fill to the top, reject one more push, then unwind from the top.
        for (int i = 0; i < DEPTH; i++) do_op(1'b1, 1'b0, 1'b0, DW'(i), ov, un, bl);
        chk("fill_full", 32'(bus.FULL), 32'd1);
        chk("fill_count", 32'(bus.COUNT), 32'd32);
        do_op(1'b1, 1'b0, 1'b0, 8'hEE, ov, un, bl);
        chk("ovf_pulse", 32'(ov), 32'd1);
        chk("ovf_count", 32'(bus.COUNT), 32'd32);
        do_op(1'b0, 1'b1, 1'b0, 8'h00, ov, un, bl);
        chk("pop_top", 32'(bus.DOUT), 32'h1F);
        do_op(1'b1, 1'b0, 1'b0, 8'h5C, ov, un, bl);
        do_op(1'b1, 1'b1, 1'b0, 8'h00, ov, un, bl);
        chk("pushpop_full", 32'(bus.DOUT), 32'h5C);
        do_op(1'b0, 1'b1, 1'b0, 8'h00, ov, un, bl);

        // Held requests: push every 4 cycles, pop every 3.
        @(negedge clk); set_req(1'b1, 1'b0, 1'b0, 8'hC1);
        repeat (8) @(negedge clk);
        set_req(1'b0, 1'b0, 1'b0, 8'h00);
        q.push_back(8'hC1); q.push_back(8'hC1);
        chk("push_rate", 32'(bus.COUNT), 32'(q.size()));
        @(negedge clk); set_req(1'b0, 1'b1, 1'b0, 8'h00);
        repeat (6) @(negedge clk);
        set_req(1'b0, 1'b0, 1'b0, 8'h00);
        m_dout = q.pop_back(); m_dout = q.pop_back();
        chk("pop_rate", 32'(bus.COUNT), 32'(q.size()));
        chk("pop_rate_dout", 32'(bus.DOUT), 32'(m_dout));

        // Reset in the middle of a write strobe.
        @(negedge clk); set_req(1'b1, 1'b0, 1'b0, 8'h77);
        @(negedge clk); set_req(1'b0, 1'b0, 1'b0, 8'h00);
        n = 0;
        while (!bus.RAM_WEN && n < 10) begin n++; @(negedge clk); end
        chk("strobe_seen", 32'(bus.RAM_WEN), 32'd1);
        #2 rst_n = 1'b0;
        #1 chk_reset_vals("midrst");
        q.delete(); m_dout = '0;
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_count", 32'(bus.COUNT), 32'd0);

`ifdef LIFO_PEEK_EN
        do_op(1'b0, 1'b0, 1'b1, 8'h00, ov, un, bl);
        chk("peek_empty_unf", 32'(un), 32'd1);
        for (int i = 0; i < 3; i++) do_op(1'b1, 1'b0, 1'b0, DW'(8'hD0 + i), ov, un, bl);
        do_op(1'b0, 1'b0, 1'b1, 8'h00, ov, un, bl);
        chk("peek_dout", 32'(bus.DOUT), 32'hD2);
        chk("peek_count", 32'(bus.COUNT), 32'd3);
        do_op(1'b1, 1'b0, 1'b1, 8'hD3, ov, un, bl);
        do_op(1'b0, 1'b1, 1'b1, 8'h00, ov, un, bl);
        chk("pop_over_peek", 32'(bus.COUNT), 32'd3);
`endif

        // Random mix, alternating push-heavy and pop-heavy phases to reach both ends.
        for (int i = 0; i < 400; i++) begin
            int   bias;
            logic pu, po, pk;
            bias = ((i / 80) % 2 == 0) ? 75 : 25;
            pu = ($urandom_range(0, 99) < bias);
            po = ($urandom_range(0, 99) < (100 - bias));
`ifdef LIFO_PEEK_EN
            pk = ($urandom_range(0, 9) == 0);
`else
            pk = 1'b0;
`endif
            do_op(pu, po, pk, DW'($urandom), ov, un, bl);
        end

        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "watchdog");
    end
endmodule
